irq_latency_sequencer: RTL and testbench
========================================

Name: irq_latency_sequencer

Overview:
Schedules periodic interrupts toward the PCIe hard IP and measures the host's response time. It raises an interrupt request, mirrors it on the GPIO tap pin used as the scope trigger, and waits for the RTAI handler to write the ACK register. It then records the latency in clock cycles and re-arms after a programmable period. It sits inside the Qsys system as an Avalon-MM slave on the BAR-mapped bus. Its irq output feeds the PCIe core interrupt input, and its irqflagtap output is exported to GPIO1_D[14].

Parameters:
CNT_W, 32, width of period, latency and event counters
TIMEOUT_CYCLES, 50000000, cycles in PENDING before an unacknowledged interrupt is abandoned (1 s at 50 MHz)

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
avs_address  in  3  word address
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_read  in  1  read strobe
avs_readdata  out  32  read data, fixed read latency 1
irq  out  1  interrupt request to PCIe core, level
irqflagtap  out  1  registered copy of irq for the GPIO scope tap

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. On reset, all registers, counters and outputs are 0 and state is IDLE.
- Register map (read/write behaviour):
  - 0 CTRL (RW): bit0 EN, bit1 ONESHOT.
  - 1 PERIOD (RW): cycles from ACK (or enable) to the next irq. A value of 0 is treated as 1.
  - 2 ACK (WO): a write of any value acknowledges the pending interrupt. Reads return 0.
  - 3 LAST_LAT (RO).
  - 4 MAX_LAT (RO): any write clears it to 0.
  - 5 COUNT (RO): number of acknowledged irqs. Any write clears it to 0.
  - 6 STATUS (RO): bit0 PENDING, bit1 TIMEOUT (sticky; cleared by a write with bit1 set), bits[3:2] state encoding.
  - 7: reads 0, writes ignored.
- Read timing: avs_readdata is valid the cycle after avs_read and holds its value otherwise. Simultaneous read and write to the same address returns the old value.
- State encoding: IDLE=0, COUNTDOWN=1, PENDING=2.
- FSM transitions:
  - IDLE: if EN=1, load period counter with max(PERIOD,1)-1 and go to COUNTDOWN.
  - COUNTDOWN: decrement each cycle. At 0, set irq=1, clear the latency counter to 0, go to PENDING.
  - PENDING: latency counter increments each cycle and saturates at 2^CNT_W-1.
    - On an ACK write: LAST_LAT = current latency counter; MAX_LAT = max(MAX_LAT, LAST_LAT); COUNT += 1 (wraps modulo 2^CNT_W); irq=0 on the next cycle.
    - After ACK, if ONESHOT=1, clear EN and go to IDLE. Otherwise reload the period counter and go to COUNTDOWN.
  - Timeout in PENDING: when the latency counter reaches TIMEOUT_CYCLES-1 with no ACK, set TIMEOUT, set irq=0, and leave LAST_LAT, MAX_LAT and COUNT unchanged. Next state follows the same ONESHOT rule as an ACK.
- Latency definition: latency 0 means the ACK write occurs in the first cycle irq is high.
- ACK edge cases:
  - An ACK write in the same cycle as the timeout terminal count wins: it is recorded as a normal ACK and TIMEOUT is not set.
  - An ACK write outside PENDING is ignored, with no counter or flag change.
- Disable mid-operation: clearing EN in any state returns the FSM to IDLE on the next cycle, with irq=0 and no recording. A CTRL write that clears EN, issued in the same cycle as an ACK write, records nothing.
- PERIOD writes take effect at the next period-counter load; an in-flight countdown is not altered.
- Output timing: irqflagtap = irq delayed by exactly 1 cycle. Both are 0 throughout reset.
- Reset mid-PENDING drops irq in the next cycle and clears all statistics.

Test Plan:
1. Reset, PERIOD=10, CTRL=1 → irq rises 10 cycles after the CTRL write commits; irqflagtap rises 1 cycle later; STATUS[3:2]=2.
2. ACK written 37 cycles after irq rise → LAST_LAT=37, MAX_LAT=37, COUNT=1, irq low next cycle, next irq 10 cycles after ACK. A second ACK at 5 cycles → LAST_LAT=5, MAX_LAT=37, COUNT=2.
3. TIMEOUT_CYCLES=100 in the bench, no ACK → irq drops after 100 cycles high; STATUS[1]=1; COUNT unchanged. Then write STATUS with bit1 set → TIMEOUT clears.
4. ONESHOT=1, EN=1, ACK → CTRL reads 2 (EN cleared), FSM IDLE, no further irq for 1000 cycles.
5. CTRL=0 written while PENDING → irq=0 next cycle, IDLE, LAST_LAT/COUNT unchanged. An ACK write while in IDLE → no change.
6. ACK on the same cycle as timeout terminal count → recorded with LAST_LAT=TIMEOUT_CYCLES-1, TIMEOUT stays 0. PERIOD=0 → irq 1 cycle after enable.

Source files
------------

// File: rtl/irq_latency_sequencer.sv
// ---------------------------------------------------------------------------
// irq_latency_sequencer
//
// Schedules periodic interrupts toward the PCIe hard IP and measures how long
// the host handler takes to acknowledge each one. After enable (or after each
// acknowledge) a programmable period elapses, irq is raised and mirrored one
// cycle later on irqflagtap (the scope trigger pin). The handler's write to the
// ACK register stops the latency counter; the result is kept as LAST_LAT, folded
// into MAX_LAT and counted in COUNT. If no ACK arrives within TIMEOUT_CYCLES,
// the interrupt is abandoned and a sticky TIMEOUT flag is raised.
//
// Ports:
//   clk            system clock (50 MHz)
//   reset          synchronous, active-high
//   avs_address    Avalon-MM word address (8 registers)
//   avs_write      write strobe
//   avs_writedata  write data
//   avs_read       read strobe
//   avs_readdata   read data, valid the cycle after avs_read, held otherwise
//   irq            level interrupt request to the PCIe core
//   irqflagtap     irq delayed by one cycle, exported to the GPIO scope tap
//
// Register map:
//   0 CTRL     RW  bit0 EN, bit1 ONESHOT
//   1 PERIOD   RW  cycles from enable/ACK to the next irq (0 behaves as 1)
//   2 ACK      WO  any write acknowledges a pending irq, reads 0
//   3 LAST_LAT RO
//   4 MAX_LAT  RO  any write clears it
//   5 COUNT    RO  acknowledged irqs, any write clears it
//   6 STATUS   RO  bit0 PENDING, bit1 TIMEOUT (write 1 to clear), [3:2] state
//   7 -        reads 0, writes ignored
// ---------------------------------------------------------------------------
module irq_latency_sequencer #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        irq,
    output logic        irqflagtap
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_PENDING   = 2'd2
    } state_t;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PERIOD   = 3'd1;
    localparam logic [2:0] ADDR_ACK      = 3'd2;
    localparam logic [2:0] ADDR_LAST_LAT = 3'd3;
    localparam logic [2:0] ADDR_MAX_LAT  = 3'd4;
    localparam logic [2:0] ADDR_COUNT    = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic             r_en;
    logic             r_oneshot;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_lat;
    logic [CNT_W-1:0] r_lastLat;
    logic [CNT_W-1:0] r_maxLat;
    logic [CNT_W-1:0] r_count;
    logic             r_timeout;
    logic             r_irq;
    logic             r_irqTap;
    logic [31:0]      r_readData;

    logic             w_wrCtrl;
    logic             w_wrPeriod;
    logic             w_wrAck;
    logic             w_wrMaxLat;
    logic             w_wrCount;
    logic             w_wrStatus;
    logic             w_enNext;
    logic             w_oneshotNext;
    logic [CNT_W-1:0] w_reload;
    logic             w_latTerminal;
    logic             w_pending;

    assign w_wrCtrl   = avs_write && (avs_address == ADDR_CTRL);
    assign w_wrPeriod = avs_write && (avs_address == ADDR_PERIOD);
    assign w_wrAck    = avs_write && (avs_address == ADDR_ACK);
    assign w_wrMaxLat = avs_write && (avs_address == ADDR_MAX_LAT);
    assign w_wrCount  = avs_write && (avs_address == ADDR_COUNT);
    assign w_wrStatus = avs_write && (avs_address == ADDR_STATUS);

    // The FSM looks at the control bits as they will be after this cycle, so a
    // CTRL write that clears EN overrides an ACK arriving in the same cycle,
    // and a write that sets EN starts the countdown on the very same edge.
    assign w_enNext      = w_wrCtrl ? avs_writedata[0] : r_en;
    assign w_oneshotNext = w_wrCtrl ? avs_writedata[1] : r_oneshot;

    // A PERIOD of 0 behaves like 1: the counter is loaded with PERIOD-1 and
    // irq rises on the edge after it reaches zero.
    assign w_reload      = (r_period == '0) ? '0 : (r_period - CNT_ONE);
    assign w_latTerminal = (r_lat == LAT_LAST);
    assign w_pending     = (r_state == ST_PENDING);

    // Main sequencer: control registers, period countdown, latency measurement
    // and the statistics it feeds. Everything that the FSM and the bus can both
    // touch lives here so each register has a single writer. Bus clears of the
    // statistics are placed last so they win over a same-cycle update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_en      <= 1'b0;
            r_oneshot <= 1'b0;
            r_period  <= '0;
            r_cnt     <= '0;
            r_lat     <= '0;
            r_lastLat <= '0;
            r_maxLat  <= '0;
            r_count   <= '0;
            r_timeout <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wrCtrl) begin
                r_en      <= avs_writedata[0];
                r_oneshot <= avs_writedata[1];
            end
            if (w_wrPeriod) begin
                r_period <= CNT_W'(avs_writedata);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_enNext) begin
                        r_cnt   <= w_reload;
                        r_state <= ST_COUNTDOWN;
                    end
                end

                ST_COUNTDOWN: begin
                    if (!w_enNext) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        r_irq   <= 1'b1;
                        r_lat   <= '0;
                        r_state <= ST_PENDING;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end

                ST_PENDING: begin
                    if (!w_enNext) begin
                        r_irq   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_wrAck || w_latTerminal) begin
                        r_irq <= 1'b0;
                        if (w_wrAck) begin
                            r_lastLat <= r_lat;
                            if (r_lat > r_maxLat) begin
                                r_maxLat <= r_lat;
                            end
                            r_count <= r_count + CNT_ONE;
                        end else begin
                            r_timeout <= 1'b1;
                        end
                        if (w_oneshotNext) begin
                            r_en    <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt   <= w_reload;
                            r_state <= ST_COUNTDOWN;
                        end
                    end else if (r_lat != LAT_MAX) begin
                        r_lat <= r_lat + CNT_ONE;
                    end
                end

                default: begin
                    r_irq   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_wrMaxLat) begin
                r_maxLat <= '0;
            end
            if (w_wrCount) begin
                r_count <= '0;
            end
            if (w_wrStatus && avs_writedata[1]) begin
                r_timeout <= 1'b0;
            end
        end
    end

    // Read port with a fixed latency of one cycle. Sampling the registers on
    // the same edge that commits a write means a simultaneous read and write
    // to one address returns the old contents. The data holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readData <= '0;
        end else if (avs_read) begin
            case (avs_address)
                ADDR_CTRL:     r_readData <= {30'd0, r_oneshot, r_en};
                ADDR_PERIOD:   r_readData <= 32'(r_period);
                ADDR_LAST_LAT: r_readData <= 32'(r_lastLat);
                ADDR_MAX_LAT:  r_readData <= 32'(r_maxLat);
                ADDR_COUNT:    r_readData <= 32'(r_count);
                ADDR_STATUS:   r_readData <= {28'd0, 2'(r_state), r_timeout, w_pending};
                default:       r_readData <= 32'd0;
            endcase
        end
    end

    // Scope tap: a registered copy of irq, so the GPIO pin lags irq by exactly
    // one cycle and both are low throughout reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irqTap <= 1'b0;
        end else begin
            r_irqTap <= r_irq;
        end
    end

    assign avs_readdata = r_readData;
    assign irq          = r_irq;
    assign irqflagtap   = r_irqTap;

endmodule

// File: tb/tb_irq_latency_sequencer.sv
// ---------------------------------------------------------------------------
// tb_irq_latency_sequencer
//
// Bench for irq_latency_sequencer with TIMEOUT_CYCLES shrunk to 100. A global
// edge counter timestamps every event: "edge k" is the k-th rising clock edge,
// and after a bus access returns, cycle holds the edge that sampled it.
// Timing rules used for expectations: a CTRL write enabling the block at edge
// W raises irq at edge W+max(PERIOD,1); an ACK at edge A re-arms so the next
// irq rises at A+max(PERIOD,1); an ACK sampled at edge R+1+L (R = rise edge)
// records latency L; with no ACK irq falls at edge R+TIMEOUT.
// ---------------------------------------------------------------------------
module tb_irq_latency_sequencer;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 100;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_PERIOD = 3'd1;
    localparam logic [2:0] A_ACK    = 3'd2;
    localparam logic [2:0] A_LAST   = 3'd3;
    localparam logic [2:0] A_MAX    = 3'd4;
    localparam logic [2:0] A_COUNT  = 3'd5;
    localparam logic [2:0] A_STATUS = 3'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        irq;
    logic        irqflagtap;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Table entry: op 0 = read and compare, 1 = write, 2 = read and write the
    // same address in one cycle and compare the returned (old) value.
    typedef struct {
        int          op;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] expRead;
    } vec_t;

    vec_t vecs[$];

    irq_latency_sequencer #(
        .CNT_W(CNT_W),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .avs_address(avs_address),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_read(avs_read),
        .avs_readdata(avs_readdata),
        .irq(irq),
        .irqflagtap(irqflagtap)
    );

    // 100 MHz bench clock and the edge counter used to timestamp events.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Hard stop in case something above never returns.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle=%0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rd,
                                 input logic [2:0] addr, input logic [31:0] data);
        avs_write     = wr;
        avs_read      = rd;
        avs_address   = addr;
        avs_writedata = data;
        tick();
        avs_write     = 1'b0;
        avs_read      = 1'b0;
    endtask

    task automatic busWrite(input logic [2:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b0, addr, data);
    endtask

    task automatic readCheck(input string name, input logic [2:0] addr,
                             input logic [31:0] expected);
        applyStimulus(1'b0, 1'b1, addr, 32'd0);
        checkOutput(name, avs_readdata, expected);
    endtask

    task automatic waitUntil(input int target);
        while (cycle < target) tick();
    endtask

    // Returns the edge after which irq was first seen high, or -1 if it did not
    // rise within the bound.
    task automatic waitIrq(input int bound, output int edgeSeen);
        edgeSeen = -1;
        for (int i = 0; i < bound && edgeSeen < 0; i++) begin
            if (irq) edgeSeen = cycle;
            else tick();
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int r, w, e;
    int per, lat;
    bit sawIrq;
    logic [31:0] mLast, mMax, mCount;
    bit mTimeout;

    initial begin
        reset         = 1'b1;
        avs_address   = '0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        avs_read      = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        checkOutput("reset irq", {31'd0, irq}, 32'd0);
        checkOutput("reset tap", {31'd0, irqflagtap}, 32'd0);
        reset = 1'b0;

        // ---------------- register map table ----------------
        for (int a = 0; a < 8; a++) vecs.push_back('{0, 3'(a), 32'd0, 32'd0});
        vecs.push_back('{1, A_PERIOD, 32'hDEADBEEF, 32'd0});
        vecs.push_back('{0, A_PERIOD, 32'd0, 32'hDEADBEEF});
        vecs.push_back('{1, A_CTRL, 32'd2, 32'd0});
        vecs.push_back('{0, A_CTRL, 32'd0, 32'd2});
        vecs.push_back('{1, A_CTRL, 32'd0, 32'd0});
        vecs.push_back('{0, A_CTRL, 32'd0, 32'd0});
        vecs.push_back('{1, 3'd7, 32'hFFFFFFFF, 32'd0});
        vecs.push_back('{0, 3'd7, 32'd0, 32'd0});
        vecs.push_back('{1, A_LAST, 32'd55, 32'd0});
        vecs.push_back('{0, A_LAST, 32'd0, 32'd0});
        vecs.push_back('{1, A_ACK, 32'hAB, 32'd0});
        vecs.push_back('{0, A_ACK, 32'd0, 32'd0});
        vecs.push_back('{1, A_STATUS, 32'hC, 32'd0});
        vecs.push_back('{0, A_STATUS, 32'd0, 32'd0});
        vecs.push_back('{2, A_PERIOD, 32'd5, 32'hDEADBEEF});
        vecs.push_back('{0, A_PERIOD, 32'd0, 32'd5});

        foreach (vecs[i]) begin
            case (vecs[i].op)
                0: readCheck($sformatf("vec%0d read a%0d", i, vecs[i].addr),
                             vecs[i].addr, vecs[i].expRead);
                1: busWrite(vecs[i].addr, vecs[i].data);
                default: begin
                    applyStimulus(1'b1, 1'b1, vecs[i].addr, vecs[i].data);
                    checkOutput($sformatf("vec%0d rw a%0d", i, vecs[i].addr),
                                avs_readdata, vecs[i].expRead);
                end
            endcase
        end

        // ---------------- 1: first interrupt ----------------
        doReset();
        busWrite(A_PERIOD, 32'd10);
        busWrite(A_CTRL, 32'd1);
        w = cycle;
        waitIrq(50, r);
        checkOutput("t1 irq rise edge", 32'(r), 32'(w + 10));
        checkOutput("t1 tap still low", {31'd0, irqflagtap}, 32'd0);
        tick();
        checkOutput("t1 tap high", {31'd0, irqflagtap}, 32'd1);
        readCheck("t1 STATUS pending", A_STATUS, 32'h9);

        // ---------------- 2: two acknowledged interrupts ----------------
        waitUntil(r + 37);
        busWrite(A_ACK, 32'd0);
        e = cycle;
        checkOutput("t2 irq low after ack", {31'd0, irq}, 32'd0);
        readCheck("t2 LAST_LAT", A_LAST, 32'd37);
        readCheck("t2 MAX_LAT", A_MAX, 32'd37);
        readCheck("t2 COUNT", A_COUNT, 32'd1);
        waitIrq(50, r);
        checkOutput("t2 re-arm rise edge", 32'(r), 32'(e + 10));
        waitUntil(r + 5);
        busWrite(A_ACK, 32'd0);
        e = cycle;
        readCheck("t2 LAST_LAT second", A_LAST, 32'd5);
        readCheck("t2 MAX_LAT kept", A_MAX, 32'd37);
        readCheck("t2 COUNT second", A_COUNT, 32'd2);

        // ---------------- 3: timeout ----------------
        waitIrq(50, r);
        checkOutput("t3 rise edge", 32'(r), 32'(e + 10));
        waitUntil(r + TIMEOUT - 1);
        checkOutput("t3 irq high before timeout", {31'd0, irq}, 32'd1);
        tick();
        checkOutput("t3 irq dropped at timeout", {31'd0, irq}, 32'd0);
        readCheck("t3 STATUS timeout", A_STATUS, 32'h6);
        readCheck("t3 COUNT unchanged", A_COUNT, 32'd2);
        readCheck("t3 LAST_LAT unchanged", A_LAST, 32'd5);
        busWrite(A_STATUS, 32'd2);
        readCheck("t3 STATUS cleared", A_STATUS, 32'h4);
        busWrite(A_CTRL, 32'd0);
        checkOutput("t3 irq low after disable", {31'd0, irq}, 32'd0);

        // ---------------- 4: oneshot ----------------
        busWrite(A_CTRL, 32'd3);
        w = cycle;
        waitIrq(50, r);
        checkOutput("t4 rise edge", 32'(r), 32'(w + 10));
        busWrite(A_ACK, 32'd0);
        readCheck("t4 CTRL EN cleared", A_CTRL, 32'd2);
        readCheck("t4 STATUS idle", A_STATUS, 32'd0);
        readCheck("t4 LAST_LAT zero latency", A_LAST, 32'd0);
        readCheck("t4 MAX_LAT", A_MAX, 32'd37);
        readCheck("t4 COUNT", A_COUNT, 32'd3);
        sawIrq = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (irq) sawIrq = 1'b1;
            tick();
        end
        checkOutput("t4 no irq for 1000 cycles", {31'd0, sawIrq}, 32'd0);

        // ---------------- 5: disable while pending, stray ACK ----------------
        busWrite(A_CTRL, 32'd1);
        waitIrq(50, r);
        waitUntil(r + 3);
        busWrite(A_CTRL, 32'd0);
        checkOutput("t5 irq low after disable", {31'd0, irq}, 32'd0);
        readCheck("t5 STATUS idle", A_STATUS, 32'd0);
        readCheck("t5 LAST_LAT unchanged", A_LAST, 32'd0);
        readCheck("t5 COUNT unchanged", A_COUNT, 32'd3);
        busWrite(A_ACK, 32'd0);
        readCheck("t5 COUNT after idle ack", A_COUNT, 32'd3);
        readCheck("t5 MAX_LAT after idle ack", A_MAX, 32'd37);
        readCheck("t5 STATUS after idle ack", A_STATUS, 32'd0);

        // ---------------- 6: ACK on terminal count, PERIOD=0 ----------------
        busWrite(A_CTRL, 32'd1);
        w = cycle;
        waitIrq(50, r);
        checkOutput("t6 rise edge", 32'(r), 32'(w + 10));
        waitUntil(r + TIMEOUT - 1);
        busWrite(A_ACK, 32'd0);
        checkOutput("t6 irq low after ack", {31'd0, irq}, 32'd0);
        readCheck("t6 LAST_LAT terminal", A_LAST, 32'(TIMEOUT - 1));
        readCheck("t6 STATUS no timeout", A_STATUS, 32'h4);
        readCheck("t6 COUNT", A_COUNT, 32'd4);
        busWrite(A_CTRL, 32'd0);
        busWrite(A_MAX, 32'd0);
        readCheck("t6 MAX_LAT cleared", A_MAX, 32'd0);
        busWrite(A_COUNT, 32'd0);
        readCheck("t6 COUNT cleared", A_COUNT, 32'd0);
        busWrite(A_PERIOD, 32'd0);
        busWrite(A_CTRL, 32'd1);
        w = cycle;
        waitIrq(10, r);
        checkOutput("t6 PERIOD=0 rise edge", 32'(r), 32'(w + 1));

        // ---------------- 7: reset while pending ----------------
        reset = 1'b1;
        tick();
        checkOutput("t7 irq low in reset", {31'd0, irq}, 32'd0);
        tick();
        checkOutput("t7 tap low in reset", {31'd0, irqflagtap}, 32'd0);
        reset = 1'b0;
        readCheck("t7 CTRL cleared", A_CTRL, 32'd0);
        readCheck("t7 LAST_LAT cleared", A_LAST, 32'd0);
        readCheck("t7 STATUS cleared", A_STATUS, 32'd0);

        // ---------------- randomized episodes vs reference model ----------------
        // The model tracks only event times and the statistics the spec defines.
        mLast = 0; mMax = 0; mCount = 0; mTimeout = 1'b0;
        for (int ep = 0; ep < 8; ep++) begin
            per = $urandom_range(0, 12);
            busWrite(A_PERIOD, 32'(per));
            busWrite(A_CTRL, 32'd1);
            e = cycle;
            for (int k = 0; k < 6; k++) begin
                waitIrq(40, r);
                checkOutput($sformatf("rnd ep%0d irq%0d rise", ep, k), 32'(r),
                            32'(e + ((per == 0) ? 1 : per)));
                lat = ($urandom_range(0, 9) == 0) ? (TIMEOUT - 1) : $urandom_range(0, TIMEOUT + 15);
                if (lat < TIMEOUT) begin
                    waitUntil(r + lat);
                    busWrite(A_ACK, 32'd0);
                    checkOutput($sformatf("rnd ep%0d irq%0d low after ack", ep, k),
                                {31'd0, irq}, 32'd0);
                    mLast  = 32'(lat);
                    mMax   = (mLast > mMax) ? mLast : mMax;
                    mCount = mCount + 1;
                end else begin
                    waitUntil(r + TIMEOUT - 1);
                    tick();
                    checkOutput($sformatf("rnd ep%0d irq%0d low at timeout", ep, k),
                                {31'd0, irq}, 32'd0);
                    mTimeout = 1'b1;
                end
                e = cycle;
            end
            busWrite(A_CTRL, 32'd0);
            readCheck($sformatf("rnd ep%0d LAST_LAT", ep), A_LAST, mLast);
            readCheck($sformatf("rnd ep%0d MAX_LAT", ep), A_MAX, mMax);
            readCheck($sformatf("rnd ep%0d COUNT", ep), A_COUNT, mCount);
            readCheck($sformatf("rnd ep%0d STATUS", ep), A_STATUS, {30'd0, mTimeout, 1'b0});
            checkOutput($sformatf("rnd ep%0d irq idle", ep), {31'd0, irq}, 32'd0);
            if (mTimeout) begin
                busWrite(A_STATUS, 32'd2);
                mTimeout = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) begin
                busWrite(A_MAX, 32'd0);
                mMax = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
